button_ctrl_array: RTL and testbench

//  Multi-channel push-button front end for the lab board: synchronises, debounces and classifies
//  N_PB raw buttons into short/long presses, and drives per-channel start/stop count enables.

---
 rtl/btn_pkg.sv | 24 ++
 rtl/btn_channel.sv | 164 ++++++++++++++++
 rtl/button_ctrl_array.sv | 88 ++++++++
 tb/tb_button_ctrl_array.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and width helpers for the push-button front end.
// Contents:
//   btn_state_t  per-channel press classifier state
//   cnt_width    bits needed to hold 0..max_val
//   mod_width    bits needed to hold 0..n-1
package btn_pkg;

   typedef enum logic [1:0] {
      BTN_IDLE    = 2'd0,
      BTN_PRESSED = 2'd1,
      BTN_LONG    = 2'd2
   } btn_state_t;

   function automatic int unsigned cnt_width(input int unsigned max_val);
      if (max_val < 1) return 1;
      return $clog2(max_val + 1);
   endfunction

   function automatic int unsigned mod_width(input int unsigned n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One push-button channel: 2-flop synchroniser, tick-sampled debounce, short/long press
// classifier and (optionally) auto-repeat while a long press is held.
// Optional feature macro: BTN_AUTO_REPEAT_EN (repeat counter and repeat_pulse).
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   tick           one-clk sample strobe from the shared prescaler
//   pb_raw         raw button, active high, asynchronous
//   pb_level       debounced level
//   short_evt      combinational: short_pulse will assert on the next edge
//   long_evt       combinational: long_pulse will assert on the next edge
//   short_pulse    registered 1-clk short-press pulse
//   long_pulse     registered 1-clk long-press pulse
//   repeat_pulse   registered 1-clk auto-repeat pulse (0 without the macro)
module btn_channel
   import btn_pkg::*;
#(
   parameter int unsigned DEB_DEPTH    = 4,
   parameter int unsigned LONG_TICKS   = 300,
   parameter int unsigned REPEAT_TICKS = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic pb_raw,
   output logic pb_level,
   output logic short_evt,
   output logic long_evt,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   localparam int unsigned HoldW = cnt_width(LONG_TICKS);
   localparam logic [HoldW-1:0] HoldLong = HoldW'(LONG_TICKS);

   logic                 sync1_q, sync2_q;
   logic [DEB_DEPTH-1:0] hist_q, hist_d;
   logic                 level_q, level_d;
   btn_state_t           state_q, state_d;
   logic [HoldW-1:0]     hold_q, hold_d;
   logic                 short_q, short_d;
   logic                 long_q, long_d;

   // Debounce: shift in one synchronised sample per tick; level only moves on a unanimous history.
   always_comb begin
      hist_d  = hist_q;
      level_d = level_q;
      if (tick) begin
         hist_d[0] = sync2_q;
         for (int i = 1; i < int'(DEB_DEPTH); i++) begin
            hist_d[i] = hist_q[i-1];
         end
         if (&hist_d) begin
            level_d = 1'b1;
         end else if (~|hist_d) begin
            level_d = 1'b0;
         end
      end
   end

   // Press classifier. Release is checked first so a release always ends the press. The long
   // decision is taken the clk after the counting tick, which keeps it in the same clk phase as
   // release detection (level only moves on a tick edge).
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      unique case (state_q)
         BTN_IDLE: begin
            if (level_q) begin
               state_d = BTN_PRESSED;
               hold_d  = '0;
            end
         end
         BTN_PRESSED: begin
            if (!level_q) begin
               state_d = BTN_IDLE;
               short_d = 1'b1;
            end else if (hold_q == HoldLong) begin
               state_d = BTN_LONG;
               long_d  = 1'b1;
            end else if (tick && (hold_q < HoldLong)) begin
               hold_d = hold_q + 1'b1;
            end
         end
         BTN_LONG: begin
            if (!level_q) begin
               state_d = BTN_IDLE;
            end
         end
         default: state_d = BTN_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= '0;
         level_q <= 1'b0;
         state_q <= BTN_IDLE;
         hold_q  <= '0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         sync1_q <= pb_raw;
         sync2_q <= sync1_q;
         hist_q  <= hist_d;
         level_q <= level_d;
         state_q <= state_d;
         hold_q  <= hold_d;
         short_q <= short_d;
         long_q  <= long_d;
      end
   end

   assign pb_level    = level_q;
   assign short_evt   = short_d;
   assign long_evt    = long_d;
   assign short_pulse = short_q;
   assign long_pulse  = long_q;

`ifdef BTN_AUTO_REPEAT_EN
   localparam int unsigned RepW = cnt_width(REPEAT_TICKS);
   localparam logic [RepW-1:0] RepTicks = RepW'(REPEAT_TICKS);

   logic [RepW-1:0] rep_q, rep_d;
   logic            rep_pulse_q, rep_pulse_d;

   always_comb begin
      rep_d       = rep_q;
      rep_pulse_d = 1'b0;
      if ((state_q == BTN_PRESSED) && (state_d == BTN_LONG)) begin
         rep_d = '0;
      end else if ((state_q == BTN_LONG) && level_q) begin
         if (rep_q == RepTicks) begin
            rep_pulse_d = 1'b1;
            rep_d       = tick ? RepW'(1) : '0;
         end else if (tick) begin
            rep_d = rep_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_q       <= '0;
         rep_pulse_q <= 1'b0;
      end else begin
         rep_q       <= rep_d;
         rep_pulse_q <= rep_pulse_d;
      end
   end

   assign repeat_pulse = rep_pulse_q;
`else
   // Repeat interval has no effect when auto-repeat is not built.
   logic unused_repeat_ticks;
   assign unused_repeat_ticks = ^REPEAT_TICKS;
   assign repeat_pulse        = 1'b0;
`endif

endmodule

// File: rtl/button_ctrl_array.sv
// Multi-channel push-button front end: shared sample-tick prescaler, N_PB debounced channels,
// per-channel run flags toggled by short presses, and a soft reset on a long press of channel 0.
// Optional feature macro: BTN_AUTO_REPEAT_EN (auto-repeat pulses while a long press is held).
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   pb_in          raw buttons, active high, asynchronous
//   pb_level       debounced levels
//   short_pulse    1-clk pulse per channel on release before the long threshold
//   long_pulse     1-clk pulse per channel on reaching the long threshold
//   repeat_pulse   1-clk auto-repeat pulses (0 without the macro)
//   count_enable   per-channel run flags
//   soft_rst_n     active-low 1-clk soft reset request
module button_ctrl_array
   import btn_pkg::*;
#(
   parameter int unsigned N_PB         = 2,
   parameter int unsigned TICK_DIV     = 1000000,
   parameter int unsigned DEB_DEPTH    = 4,
   parameter int unsigned LONG_TICKS   = 300,
   parameter int unsigned REPEAT_TICKS = 20
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_PB-1:0] pb_in,
   output logic [N_PB-1:0] pb_level,
   output logic [N_PB-1:0] short_pulse,
   output logic [N_PB-1:0] long_pulse,
   output logic [N_PB-1:0] repeat_pulse,
   output logic [N_PB-1:0] count_enable,
   output logic            soft_rst_n
);

   localparam int unsigned CntW = mod_width(TICK_DIV);
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            tick;
   logic [N_PB-1:0] short_evt, long_evt;
   logic [N_PB-1:0] en_q, en_d;

   assign tick = (cnt_q == CntMax);

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   for (genvar g = 0; g < int'(N_PB); g++) begin : g_ch
      btn_channel #(
         .DEB_DEPTH   (DEB_DEPTH),
         .LONG_TICKS  (LONG_TICKS),
         .REPEAT_TICKS(REPEAT_TICKS)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .tick        (tick),
         .pb_raw      (pb_in[g]),
         .pb_level    (pb_level[g]),
         .short_evt   (short_evt[g]),
         .long_evt    (long_evt[g]),
         .short_pulse (short_pulse[g]),
         .long_pulse  (long_pulse[g]),
         .repeat_pulse(repeat_pulse[g])
      );
   end

   // Run flags change on the same edge the pulses rise; a channel-0 long press clears all flags
   // and overrides any short-press toggle landing on that edge.
   always_comb begin
      en_d = en_q ^ short_evt;
      if (long_evt[0]) begin
         en_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         en_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         en_q  <= en_d;
      end
   end

   assign count_enable = en_q;
   assign soft_rst_n   = ~long_pulse[0];

endmodule

// File: tb/tb_button_ctrl_array.sv
module tb_button_ctrl_array;

   localparam int unsigned N  = 2;
   localparam int unsigned TD = 4;
   localparam int unsigned DD = 3;
   localparam int unsigned LT = 5;
   localparam int unsigned RT = 2;
`ifdef BTN_AUTO_REPEAT_EN
   localparam bit RepEn  = 1'b1;
   localparam int ExpRep = 3;
`else
   localparam bit RepEn  = 1'b0;
   localparam int ExpRep = 0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] pb_in = '0;
   logic [N-1:0] pb_level, short_pulse, long_pulse, repeat_pulse, count_enable;
   logic         soft_rst_n;

   always #5 clk = ~clk;

   button_ctrl_array #(
      .N_PB        (N),
      .TICK_DIV    (TD),
      .DEB_DEPTH   (DD),
      .LONG_TICKS  (LT),
      .REPEAT_TICKS(RT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pb_in       (pb_in),
      .pb_level    (pb_level),
      .short_pulse (short_pulse),
      .long_pulse  (long_pulse),
      .repeat_pulse(repeat_pulse),
      .count_enable(count_enable),
      .soft_rst_n  (soft_rst_n)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Debounce as "run length of equal samples"; presses as records of held ticks.
   int           m_cnt;
   logic [N-1:0] m_s1, m_s2, m_level, m_last;
   int           m_run [N];
   bit           m_active [N];
   bit           m_islong [N];
   int           m_held [N];
   int           m_rep [N];
   logic [N-1:0] e_short, e_long, e_rep, e_en;

   task automatic m_reset();
      m_cnt = 0; m_s1 = '0; m_s2 = '0; m_level = '0; m_last = '0;
      e_short = '0; e_long = '0; e_rep = '0; e_en = '0;
      for (int c = 0; c < int'(N); c++) begin
         m_run[c] = DD; m_active[c] = 0; m_islong[c] = 0; m_held[c] = 0; m_rep[c] = 0;
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_reset();
         end else begin
            bit           tk;
            logic [N-1:0] lvl_old, smp, sh, lg, rp;
            tk = (m_cnt == int'(TD) - 1);
            m_cnt = (m_cnt + 1) % int'(TD);
            lvl_old = m_level;
            smp = m_s2;
            m_s2 = m_s1;
            m_s1 = pb_in;
            sh = '0; lg = '0; rp = '0;
            for (int c = 0; c < int'(N); c++) begin
               if (tk) begin
                  if (smp[c] == m_last[c]) m_run[c]++;
                  else begin
                     m_last[c] = smp[c];
                     m_run[c] = 1;
                  end
                  if (m_run[c] >= int'(DD)) m_level[c] = m_last[c];
               end
               if (!m_active[c]) begin
                  if (lvl_old[c]) begin
                     m_active[c] = 1; m_islong[c] = 0; m_held[c] = 0;
                  end
               end else if (!lvl_old[c]) begin
                  if (!m_islong[c]) sh[c] = 1'b1;
                  m_active[c] = 0;
               end else if (!m_islong[c]) begin
                  if (m_held[c] == int'(LT)) begin
                     m_islong[c] = 1; lg[c] = 1'b1; m_rep[c] = 0;
                  end else if (tk) m_held[c]++;
               end else if (RepEn) begin
                  if (m_rep[c] == int'(RT)) begin
                     rp[c] = 1'b1;
                     m_rep[c] = tk ? 1 : 0;
                  end else if (tk) m_rep[c]++;
               end
            end
            e_short = sh; e_long = lg; e_rep = rp;
            if (lg[0]) e_en = '0;
            else e_en = e_en ^ sh;
         end
      end
   end

   // ---------------- per-cycle compare + event counters ----------------
   int           n_short [N], n_long [N], n_rep [N], n_rise [N], n_fall [N];
   int           n_soft;
   logic [N-1:0] prev_level = '0;

   task automatic clr_counts();
      for (int c = 0; c < int'(N); c++) begin
         n_short[c] = 0; n_long[c] = 0; n_rep[c] = 0; n_rise[c] = 0; n_fall[c] = 0;
      end
      n_soft = 0;
   endtask

   initial begin
      clr_counts();
      forever begin
         @(negedge clk);
         check("pb_level", pb_level, m_level);
         check("short_pulse", short_pulse, e_short);
         check("long_pulse", long_pulse, e_long);
         check("repeat_pulse", repeat_pulse, e_rep);
         check("count_enable", count_enable, e_en);
         check("soft_rst_n", soft_rst_n, !e_long[0]);
         for (int c = 0; c < int'(N); c++) begin
            if (short_pulse[c] === 1'b1) n_short[c]++;
            if (long_pulse[c] === 1'b1) n_long[c]++;
            if (repeat_pulse[c] === 1'b1) n_rep[c]++;
            if (pb_level[c] === 1'b1 && prev_level[c] === 1'b0) n_rise[c]++;
            if (pb_level[c] === 1'b0 && prev_level[c] === 1'b1) n_fall[c]++;
         end
         if (soft_rst_n === 1'b0) n_soft++;
         prev_level = pb_level;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_level(input int ch, input logic val, input int lim, input string name);
      int n = 0;
      while (pb_level[ch] !== val && n < lim) begin
         step(1);
         n++;
      end
      check(name, pb_level[ch], val);
   endtask

   task automatic short_press(input int ch);
      pb_in[ch] = 1'b1;
      wait_level(ch, 1'b1, 40, "press_rise");
      pb_in[ch] = 1'b0;
      wait_level(ch, 1'b0, 40, "press_fall");
      step(2);
   endtask

   initial begin
      int n;
      // 1. reset with both buttons held
      pb_in = 2'b11;
      step(3);
      check("rst_level", pb_level, 2'b00);
      check("rst_pulses", {short_pulse, long_pulse, repeat_pulse}, 6'b0);
      check("rst_en", count_enable, 2'b00);
      check("rst_soft", soft_rst_n, 1'b1);
      rst_n = 1'b1;
      clr_counts();
      n = 0;
      while (pb_level !== 2'b11 && n < (2 + 3 + 1) * int'(TD) + 2) begin
         step(1);
         n++;
      end
      check("rst_release_level", pb_level, 2'b11);
      step(40);
      pb_in = 2'b00;
      wait_level(0, 1'b0, 40, "s1_fall0");
      wait_level(1, 1'b0, 40, "s1_fall1");
      step(2);
      check("s1_long0", n_long[0], 1);
      check("s1_long1", n_long[1], 1);
      check("s1_short", n_short[0] + n_short[1], 0);
      check("s1_soft", n_soft, 1);
      check("s1_en", count_enable, 2'b00);

      // 2. bouncing ch1 then a clean short press
      clr_counts();
      for (int i = 0; i < 40; i++) begin
         pb_in[1] = logic'((i / 3) % 2);
         step(1);
      end
      check("s2_bounce_level", pb_level, 2'b00);
      short_press(1);
      check("s2_short1", n_short[1], 1);
      check("s2_rise1", n_rise[1], 1);
      check("s2_fall1", n_fall[1], 1);
      check("s2_en", count_enable, 2'b10);

      // 3. second short press on ch1; ch0 untouched
      short_press(1);
      check("s3_short1", n_short[1], 2);
      check("s3_en", count_enable, 2'b00);
      check("s3_ch0_quiet", n_short[0] + n_long[0] + n_rise[0], 0);

      // 4. ch1 enabled, long press on ch0 clears it
      short_press(1);
      check("s4_en_pre", count_enable, 2'b10);
      clr_counts();
      pb_in[0] = 1'b1;
      step(10 * int'(TD));
      pb_in[0] = 1'b0;
      wait_level(0, 1'b0, 40, "s4_fall0");
      step(2);
      check("s4_long0", n_long[0], 1);
      check("s4_soft", n_soft, 1);
      check("s4_short0", n_short[0], 0);
      check("s4_en", count_enable, 2'b00);

      // 5. ch1 release lands in the same clk as ch0 long
      short_press(1);
      check("s5_en_pre", count_enable, 2'b10);
      pb_in = 2'b11;
      wait_level(1, 1'b1, 40, "s5_rise");
      check("s5_rise_both", pb_level, 2'b11);
      step(2 * int'(TD));
      pb_in[1] = 1'b0;
      n = 0;
      while (short_pulse[1] !== 1'b1 && n < 40) begin
         step(1);
         n++;
      end
      check("s5_short1", short_pulse[1], 1'b1);
      check("s5_long0", long_pulse[0], 1'b1);
      check("s5_soft", soft_rst_n, 1'b0);
      check("s5_en", count_enable, 2'b00);
      step(4);
      pb_in[0] = 1'b0;
      wait_level(0, 1'b0, 40, "s5_fall0");
      step(2);

      // 6. long hold on ch1, auto-repeat when built
      clr_counts();
      pb_in[1] = 1'b1;
      wait_level(1, 1'b1, 40, "s6_rise");
      step(9 * int'(TD));
      pb_in[1] = 1'b0;
      wait_level(1, 1'b0, 40, "s6_fall");
      step(4);
      check("s6_long1", n_long[1], 1);
      check("s6_rep1", n_rep[1], ExpRep);
      check("s6_short1", n_short[1], 0);
      check("s6_soft", n_soft, 0);
      check("s6_en", count_enable, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
